// File: rtl/arb_pkg.sv
// Shared types and constants for the two-requester bus arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_A = 2'b01,
    GRANT_B = 2'b10
  } arb_state_t;

  localparam int ARB_WIDTH = 16;

endpackage

// File: rtl/Mux_16w_2to1.sv
// Fixed 16-bit two-input word multiplexer: Sel=1 passes A, Sel=0 passes B.
module Mux_16w_2to1 (
  input  logic        Sel,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] M
);

  always_comb begin
    if (Sel) begin
      M = A;
    end else begin
      M = B;
    end
  end

endmodule

// File: rtl/mux_bus_arbiter.sv
// Two-requester arbiter owning a shared bus word selected through Mux_16w_2to1.
// Optional macro ARB_HOLD_LIMIT_EN caps consecutive owner beats at HOLD_MAX while the other side waits.
module mux_bus_arbiter
  import arb_pkg::*;
#(
  parameter int          WIDTH    = ARB_WIDTH,
  parameter int unsigned HOLD_MAX = 32'd4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             ReqA,
  input  logic             ReqB,
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  output logic             GntA,
  output logic             GntB,
  output logic             Sel,
  output logic [WIDTH-1:0] BusOut,
  output logic             BusValid
);

  arb_state_t           state_q, state_d;
  logic                 last_a_q, last_a_d;
  logic [WIDTH-1:0]     bus_q, bus_d;
  logic                 valid_q, valid_d;
  logic                 hold_sw_s;
  logic                 fire_s;
  logic                 sel_s;
  logic [ARB_WIDTH-1:0] mux_out_s;

  assign sel_s = (state_q == GRANT_A);

  Mux_16w_2to1 u_mux (
    .Sel (sel_s),
    .A   (DataA),
    .B   (DataB),
    .M   (mux_out_s)
  );

`ifdef ARB_HOLD_LIMIT_EN
  localparam int               CNT_W   = $clog2(HOLD_MAX + 32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Owner has used its quota and the other side is waiting: force a handover.
  always_comb begin
    hold_sw_s = 1'b0;
    case (state_q)
      GRANT_A: hold_sw_s = (cnt_q == CNT_MAX) && ReqB;
      GRANT_B: hold_sw_s = (cnt_q == CNT_MAX) && ReqA;
      default: hold_sw_s = 1'b0;
    endcase
  end

  always_comb begin
    if ((state_q == IDLE) || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (fire_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_hold_s;

  assign hold_sw_s     = 1'b0;
  assign unused_hold_s = (HOLD_MAX != 32'd0);
`endif

  // A handover cycle (request drop or forced switch) never carries a beat.
  always_comb begin
    state_d = state_q;
    fire_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ReqA && ReqB) begin
          state_d = last_a_q ? GRANT_B : GRANT_A;
        end else if (ReqA) begin
          state_d = GRANT_A;
        end else if (ReqB) begin
          state_d = GRANT_B;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT_A: begin
        if (hold_sw_s) begin
          state_d = GRANT_B;
        end else if (ReqA) begin
          state_d = GRANT_A;
          fire_s  = 1'b1;
        end else if (ReqB) begin
          state_d = GRANT_B;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT_B: begin
        if (hold_sw_s) begin
          state_d = GRANT_A;
        end else if (ReqB) begin
          state_d = GRANT_B;
          fire_s  = 1'b1;
        end else if (ReqA) begin
          state_d = GRANT_A;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        fire_s  = 1'b0;
      end
    endcase
  end

  always_comb begin
    valid_d = fire_s;
    if (fire_s) begin
      bus_d    = mux_out_s;
      last_a_d = (state_q == GRANT_A);
    end else begin
      bus_d    = bus_q;
      last_a_d = last_a_q;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      last_a_q <= 1'b0;
      bus_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_a_q <= last_a_d;
      bus_q    <= bus_d;
      valid_q  <= valid_d;
    end
  end

  assign GntA     = (state_q == GRANT_A);
  assign GntB     = (state_q == GRANT_B);
  assign Sel      = sel_s;
  assign BusOut   = bus_q;
  assign BusValid = valid_q;

endmodule

// File: tb/tb_mux_bus_arbiter.sv
// Directed + random bench for mux_bus_arbiter with a queue scoreboard of expected bus words.
module tb_mux_bus_arbiter;

  localparam int HOLD = 4;

  logic        Clk;
  logic        Rst_n;
  logic        ReqA;
  logic        ReqB;
  logic [15:0] DataA;
  logic [15:0] DataB;
  logic        GntA;
  logic        GntB;
  logic        Sel;
  logic [15:0] BusOut;
  logic        BusValid;

  int          n_cmp = 0;
  int          n_bad = 0;

  // reference state: 0 idle, 1 A owns, 2 B owns
  int          m_st;
  bit          m_last;
  int          m_cnt;
  logic [15:0] exp_q[$];

  mux_bus_arbiter dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .ReqA     (ReqA),
    .ReqB     (ReqB),
    .DataA    (DataA),
    .DataB    (DataB),
    .GntA     (GntA),
    .GntB     (GntB),
    .Sel      (Sel),
    .BusOut   (BusOut),
    .BusValid (BusValid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st   = 0;
    m_last = 1'b0;
    m_cnt  = 0;
    exp_q.delete();
  endtask

  // Predict one edge from the inputs now applied, clock it, then check the DUT.
  task automatic tick(input string tag);
    bit          sw;
    bit          fire;
    int          nst;
    logic [15:0] w;
    sw = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
    if (m_st == 1) sw = (m_cnt == HOLD) && ReqB;
    if (m_st == 2) sw = (m_cnt == HOLD) && ReqA;
`endif
    fire = !sw && (((m_st == 1) && ReqA) || ((m_st == 2) && ReqB));
    if (fire) exp_q.push_back((m_st == 1) ? DataA : DataB);
    case (m_st)
      0:       nst = (ReqA && ReqB) ? (m_last ? 2 : 1) : (ReqA ? 1 : (ReqB ? 2 : 0));
      1:       nst = sw ? 2 : (ReqA ? 1 : (ReqB ? 2 : 0));
      default: nst = sw ? 1 : (ReqB ? 2 : (ReqA ? 1 : 0));
    endcase
    if (fire) m_last = (m_st == 1);
    if ((nst != m_st) || (m_st == 0)) m_cnt = 0;
    else if (fire && (m_cnt < HOLD)) m_cnt++;
    m_st = nst;
    @(posedge Clk);
    #1;
    chk({tag, ".GntA"}, {31'd0, GntA}, {31'd0, (m_st == 1)});
    chk({tag, ".GntB"}, {31'd0, GntB}, {31'd0, (m_st == 2)});
    chk({tag, ".Sel"}, {31'd0, Sel}, {31'd0, (m_st == 1)});
    chk({tag, ".excl"}, {31'd0, GntA & GntB}, 32'd0);
    chk({tag, ".BusValid"}, {31'd0, BusValid}, {31'd0, fire});
    if (BusValid === 1'b1) begin
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_bad++;
        $error("FAIL %s.sb_empty: observed BusValid=1 expected no word", tag);
      end
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        chk({tag, ".BusOut"}, {16'd0, BusOut}, {16'd0, w});
      end
    end
  endtask

  initial begin
    int na;
    int nb;
    int ngb;
    model_reset();
    Rst_n = 1'b0;
    ReqA  = 1'b0;
    ReqB  = 1'b0;
    DataA = 16'h0000;
    DataB = 16'h0000;
    #12;
    chk("rst.GntA", {31'd0, GntA}, 32'd0);
    chk("rst.GntB", {31'd0, GntB}, 32'd0);
    chk("rst.Sel", {31'd0, Sel}, 32'd0);
    chk("rst.BusValid", {31'd0, BusValid}, 32'd0);
    chk("rst.BusOut", {16'd0, BusOut}, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // 1: single requester burst
    ReqA = 1'b1; DataA = 16'h1111;
    tick("t1.grant");
    chk("t1.GntA_c1", {31'd0, GntA}, 32'd1);
    tick("t1.b1");
    chk("t1.word1", {16'd0, BusOut}, 32'h1111);
    DataA = 16'h2222;
    tick("t1.b2");
    DataA = 16'h3333;
    tick("t1.b3");
    chk("t1.word3", {16'd0, BusOut}, 32'h3333);
    ReqA = 1'b0;
    tick("t1.idle");

    // 4: reset in the middle of a burst
    ReqA = 1'b1; DataA = 16'h7777;
    tick("t4.grant");
    tick("t4.b1");
    Rst_n = 1'b0;
    #2;
    chk("t4.GntA", {31'd0, GntA}, 32'd0);
    chk("t4.BusValid", {31'd0, BusValid}, 32'd0);
    chk("t4.BusOut", {16'd0, BusOut}, 32'd0);
    model_reset();
    ReqA = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick("t4.quiet");

    // 2: tie after reset goes to A, handover to B, next tie back to A
    ReqA = 1'b1; ReqB = 1'b1; DataA = 16'hAAAA; DataB = 16'hBBBB;
    tick("t2.tie");
    chk("t2.firstA", {31'd0, GntA}, 32'd1);
    tick("t2.a1");
    ReqA = 1'b0;
    tick("t2.dead");
    chk("t2.dead_valid", {31'd0, BusValid}, 32'd0);
    tick("t2.b1");
    chk("t2.wordB", {16'd0, BusOut}, 32'hBBBB);
    ReqB = 1'b0;
    tick("t2.idle");
    ReqA = 1'b1; ReqB = 1'b1;
    tick("t2.tie2");
    chk("t2.tie2A", {31'd0, GntA}, 32'd1);
    tick("t2.a2");
    ReqA = 1'b0; ReqB = 1'b0;
    tick("t2.idle2");

    // 3: tie with A served last goes to B
    ReqA = 1'b1; ReqB = 1'b1; DataA = 16'h3C3C; DataB = 16'hC3C3;
    tick("t3.tie");
    chk("t3.GntB", {31'd0, GntB}, 32'd1);
    chk("t3.Sel", {31'd0, Sel}, 32'd0);
    tick("t3.b1");
    chk("t3.wordB", {16'd0, BusOut}, 32'hC3C3);
    ReqA = 1'b0; ReqB = 1'b0;
    tick("t3.idle");

    // 5: both held high; hold limit splits beats, otherwise A keeps the bus
    ReqA = 1'b1; ReqB = 1'b1; DataA = 16'hA5A5; DataB = 16'h5A5A;
    na = 0; nb = 0; ngb = 0;
    for (int i = 0; i < 12; i++) begin
      tick("t5.hold");
      if (BusValid === 1'b1 && BusOut === 16'hA5A5) na++;
      if (BusValid === 1'b1 && BusOut === 16'h5A5A) nb++;
      if (GntB === 1'b1) ngb++;
    end
`ifdef ARB_HOLD_LIMIT_EN
    chk("t5.beatsA", na, 32'd5);
    chk("t5.beatsB", nb, 32'd4);
`else
    chk("t5.beatsA", na, 32'd11);
    chk("t5.gntB_cycles", ngb, 32'd0);
`endif
    ReqA = 1'b0; ReqB = 1'b0;
    tick("t5.drop");

    // 6: random traffic
    for (int i = 0; i < 20; i++) begin
      ReqA  = 1'($urandom_range(1, 0));
      ReqB  = 1'($urandom_range(1, 0));
      DataA = 16'($urandom);
      DataB = 16'($urandom);
      tick("t6.rand");
    end
    ReqA = 1'b0; ReqB = 1'b0;
    tick("t6.drain1");
    tick("t6.drain2");
    chk("sb.leftover", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
